rv_mem_stage: RTL and testbench
===============================

# rv_mem_stage

Memory stage of the rvcpu pipeline: it sits between execute and writeback. It consumes `stage_ex_t` beats from execute and carries out loads and stores on a single-outstanding data-memory bus. It produces `stage_mem_t` beats toward writeback. Non-memory beats pass through with one register of latency; memory beats stall upstream until the bus transaction completes.

## Interface
- `Width`, default `rvcpu::Width` (32): data/address width; byte-lane logic is fixed at 4 lanes.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `ex_valid  in  1`: execute beat valid.
- `ex_ready  out  1`: stage accepts the beat this cycle.
- `ex_in  in  $bits(stage_ex_t)`: `res` is the ALU result or the effective address.
- `ex_mem  in  $bits(mem_req_t)`: memory op, size, unsigned flag, store data.
- `dmem_req  out  1`: bus request; held until `dmem_gnt`.
- `dmem_gnt  in  1`: request accepted.
- `dmem_we  out  1`: 1 = store.
- `dmem_addr  out  Width`: word-aligned address (`[1:0]` = 0).
- `dmem_be  out  4`: byte enables.
- `dmem_wdata  out  Width`: lane-replicated store data.
- `dmem_rvalid  in  1`: load data valid.
- `dmem_rdata  in  Width`: load data word.
- `mem_valid  out  1`: writeback beat valid.
- `mem_ready  in  1`: writeback accepts.
- `mem_out  out  $bits(stage_mem_t)`: writeback beat.
- `mem_fault  out  1`: misaligned access flag, qualified by `mem_valid`.

## Operation
- **Accept rule:** `ex_ready = (state==IDLE) && (!mem_valid || mem_ready)`. A transfer occurs when `ex_valid && ex_ready`.
- **States:** IDLE, REQ, RSP.
- **`op==mem_none`:** stay in IDLE. Load the output register with `pc`, `rd`, `rd_valid`, `rd_data = res`.
- **`op==mem_load`:** IDLE→REQ. Latch `pc`, `rd`, `rd_valid`, size, unsigned flag and `addr[1:0]`.
- **`op==mem_store`:** IDLE→REQ. Latch the same fields; the output beat is forced to `rd_valid = 0`.
- **REQ:**
  - `dmem_req = 1`. Address, `we`, `be` and `wdata` stay stable until `dmem_gnt`.
  - On `gnt`, a store goes REQ→IDLE and writes the output beat.
  - On `gnt`, a load goes REQ→RSP.
- **RSP:** on `dmem_rvalid`, write the output beat with extracted data, then go RSP→IDLE.
- **Byte enables:**
  - byte: `4'b0001 << a[1:0]`
  - half: `4'b0011 << {a[1],1'b0}`
  - word: `4'b1111`
- **Store data:** byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- **Load extraction:** select the byte or half at `a[1:0]`, then zero-extend if unsigned, otherwise sign-extend to `Width`.
- **Output register:** holds its beat while `mem_valid && !mem_ready`. The accept rule guarantees the register is empty or draining whenever REQ/RSP finishes, so completion never stalls.
- **Spurious inputs:** `dmem_rvalid` is ignored outside RSP; `dmem_gnt` is ignored outside REQ.
- **Reset:**
  - state = IDLE
  - `mem_valid = 0`, `dmem_req = 0`, `mem_fault = 0`
  - `mem_out = 0`, `dmem_addr`/`be`/`wdata`/`we` = 0
- **Reset mid-transaction:** reset in REQ/RSP abandons the transaction. A later `rvalid` is dropped because the stage is in IDLE.

## Timing
- **Pass-through:** accept at cycle 0 → `mem_valid` at cycle 1.
- **Store:** accept at 0, `dmem_req` from cycle 1 (registered). `gnt` at cycle k → `mem_valid` at k+1.
- **Load:** `gnt` at k, `rvalid` at r > k → `mem_valid` at r+1. The best case is a 3-cycle load.
- **Throughput:** back-to-back pass-through beats sustain 1/cycle when `mem_ready = 1`.
- **Single outstanding:** at most one bus transaction is in flight.

## Configuration
- Macro: `RVCPU_MISALIGN_TRAP_EN`.
- **Defined:** a half access with `a[0]` set, or a word access with `a[1:0] != 0`, issues no bus request. The stage stays in IDLE and writes the output beat next cycle with `mem_fault = 1` and `rd_valid = 0`.
- **Undefined:**
  - `mem_fault` is tied to 0.
  - Misaligned half accesses use `a[1]` for lane selection.
  - Misaligned word accesses use all lanes.
  - The low address bits are otherwise ignored, i.e. the access is silently aligned.

## Structure
- **Additions to package `rvcpu`:**
  - `mem_op_t` enum: `mem_none`, `mem_load`, `mem_store`.
  - `mem_size_t` enum: `sz_byte`, `sz_half`, `sz_word`.
  - `mem_req_t` packed struct: `op`, `size`, `is_unsigned`, `wdata`.
- **Sub-module `rv_lsu_align`:** purely combinational; computes `be`, `wdata` replication, load extraction and the misalignment flag. The FSM and registers stay in `rv_mem_stage`.

## Test plan
1. Pass-through `res=0x0000_1234`, `rd=5`, `mem_ready=1`, four consecutive beats → four `mem_out` beats on consecutive cycles, `rd_data=0x1234`, `dmem_req` never asserted.
2. Signed byte load at `0x103`, `gnt` at cycle 1, `rvalid` at cycle 2 with `rdata=0x8011_2233` → `dmem_addr=0x100`, `be=4'b1000`, `rd_data=0xFFFF_FF80` at cycle 3. The same load unsigned → `0x0000_0080`.
3. Half store at `0x202`, `wdata=0x1234_ABCD`, `gnt` delayed 3 cycles → `dmem_req`, `addr=0x200`, `be=4'b1100`, `wdata=0xABCD_ABCD` held for 3 cycles. `ex_ready=0` throughout; then `mem_valid` with `rd_valid=0`.
4. Load completes while `mem_ready=0` for 4 cycles → `mem_out` held stable, `ex_ready=0` until the beat drains; spurious `rvalid` in IDLE → no output.
5. Word load at `0x101`:
   - With `RVCPU_MISALIGN_TRAP_EN`: no `dmem_req`, `mem_fault=1`, `rd_valid=0` at cycle 1.
   - Without it: `addr=0x100`, `be=4'b1111`, `mem_fault=0`.
6. `rst` asserted in RSP, then `rvalid` arrives → all outputs at reset values, no `mem_valid`; the next pass-through beat proceeds normally.

Source files
------------

// File: rtl/rvcpu_pkg.sv
// rvcpu: shared pipeline types for the memory stage (widths, bus op/size enums, stage beats)
package rvcpu;
    localparam int Width = 32;
    typedef enum logic [1:0] {mem_none, mem_load, mem_store} mem_op_t;
    typedef enum logic [1:0] {sz_byte, sz_half, sz_word} mem_size_t;
    typedef enum logic [1:0] {IDLE, REQ, RSP} mem_state_t;
    typedef struct packed {
        mem_op_t          op;
        mem_size_t        size;
        logic             is_unsigned;
        logic [Width-1:0] wdata;
    } mem_req_t;
    typedef struct packed {
        logic [Width-1:0] pc;
        logic [4:0]       rd;
        logic             rd_valid;
        logic [Width-1:0] res;
    } stage_ex_t;
    typedef struct packed {
        logic [Width-1:0] pc;
        logic [4:0]       rd;
        logic             rd_valid;
        logic [Width-1:0] rd_data;
    } stage_mem_t;
endpackage

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: combinational byte-lane helper for the memory stage
// Ports: size/addr_lo/is_unsigned describe the access; wdata -> wdata_rep (lane replicated),
// rdata -> rdata_ext (extracted and extended), be = byte enables, misaligned = natural-alignment violation
module rv_lsu_align
    import rvcpu::*;
#(
    parameter int Width = rvcpu::Width
) (
    input  mem_size_t        size,
    input  logic [1:0]       addr_lo,
    input  logic             is_unsigned,
    input  logic [Width-1:0] wdata,
    input  logic [Width-1:0] rdata,
    output logic [3:0]       be,
    output logic [Width-1:0] wdata_rep,
    output logic [Width-1:0] rdata_ext,
    output logic             misaligned
);
    logic [7:0]  b;
    logic [15:0] h;
    // half lanes only look at addr_lo[1], so an unaligned half is silently aligned
    assign b = rdata[{addr_lo, 3'b000} +: 8];
    assign h = rdata[{addr_lo[1], 4'b0000} +: 16];
    always_comb begin
        be = size == sz_byte ? 4'b0001 << addr_lo :
             size == sz_half ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
        wdata_rep = size == sz_byte ? {4{wdata[7:0]}} :
                    size == sz_half ? {2{wdata[15:0]}} : wdata;
        rdata_ext = size == sz_byte ? {{(Width-8){~is_unsigned & b[7]}}, b} :
                    size == sz_half ? {{(Width-16){~is_unsigned & h[15]}}, h} : rdata;
        misaligned = (size == sz_half && addr_lo[0]) || (size == sz_word && addr_lo != 2'b00);
    end
endmodule

// File: rtl/rv_mem_stage.sv
// rv_mem_stage: pipeline memory stage, single-outstanding data bus, execute -> writeback
// Ports: ex_valid/ex_ready/ex_in/ex_mem = execute beat; dmem_* = data bus;
// mem_valid/mem_ready/mem_out/mem_fault = writeback beat. Macro RVCPU_MISALIGN_TRAP_EN
// turns misaligned half/word accesses into a faulting beat instead of a silently aligned access.
module rv_mem_stage
    import rvcpu::*;
#(
    parameter int Width = rvcpu::Width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  stage_ex_t        ex_in,
    input  mem_req_t         ex_mem,
    output logic             dmem_req,
    input  logic             dmem_gnt,
    output logic             dmem_we,
    output logic [Width-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [Width-1:0] dmem_wdata,
    input  logic             dmem_rvalid,
    input  logic [Width-1:0] dmem_rdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output stage_mem_t       mem_out,
    output logic             mem_fault
);
    mem_state_t       state, state_nx;
    mem_size_t        size_q, al_size;
    logic [Width-1:0] pc_q, wdata_rep, rdata_ext;
    logic [4:0]       rd_q;
    logic [3:0]       be;
    logic [1:0]       a_q, al_a;
    logic             rd_valid_q, uns_q, fault_q, accept, is_mem, trap, start;
    // in IDLE the helper sees the incoming beat, otherwise the latched access
    assign al_size = state == IDLE ? ex_mem.size : size_q;
    assign al_a = state == IDLE ? ex_in.res[1:0] : a_q;
    assign accept = ex_valid && ex_ready;
    assign is_mem = ex_mem.op != mem_none;
    assign start = accept && is_mem && !trap;
    assign mem_fault = fault_q;
`ifdef RVCPU_MISALIGN_TRAP_EN
    logic misaligned;
    assign trap = is_mem && misaligned;
`else
    assign trap = 1'b0;
`endif
    rv_lsu_align #(.Width(Width)) u_align (
        .size(al_size),
        .addr_lo(al_a),
        .is_unsigned(uns_q),
        .wdata(ex_mem.wdata),
        .rdata(dmem_rdata),
        .be(be),
        .wdata_rep(wdata_rep),
        .rdata_ext(rdata_ext),
`ifdef RVCPU_MISALIGN_TRAP_EN
        .misaligned(misaligned)
`else
        .misaligned()
`endif
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (start ? REQ : IDLE) :
                   state == REQ ? (dmem_gnt ? (dmem_we ? IDLE : RSP) : REQ) :
                   (dmem_rvalid ? IDLE : RSP);
    end
    always_comb begin
        dmem_req = state == REQ;
        ex_ready = state == IDLE && (!mem_valid || mem_ready);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            size_q     <= sz_byte;
            uns_q      <= 1'b0;
            a_q        <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            mem_valid  <= 1'b0;
            mem_out    <= '0;
            fault_q    <= 1'b0;
        end else begin
            if (start) begin
                pc_q       <= ex_in.pc;
                rd_q       <= ex_in.rd;
                rd_valid_q <= ex_in.rd_valid;
                size_q     <= ex_mem.size;
                uns_q      <= ex_mem.is_unsigned;
                a_q        <= ex_in.res[1:0];
                dmem_we    <= ex_mem.op == mem_store;
                dmem_addr  <= {ex_in.res[Width-1:2], 2'b00};
                dmem_be    <= be;
                dmem_wdata <= wdata_rep;
            end
            // completions never collide: the accept rule kept the register empty or draining
            if (accept && (!is_mem || trap)) begin
                mem_valid <= 1'b1;
                mem_out   <= '{pc: ex_in.pc, rd: ex_in.rd, rd_valid: ex_in.rd_valid && !trap, rd_data: ex_in.res};
                fault_q   <= trap;
            end else if (state == REQ && dmem_gnt && dmem_we) begin
                mem_valid <= 1'b1;
                mem_out   <= '{pc: pc_q, rd: rd_q, rd_valid: 1'b0, rd_data: '0};
                fault_q   <= 1'b0;
            end else if (state == RSP && dmem_rvalid) begin
                mem_valid <= 1'b1;
                mem_out   <= '{pc: pc_q, rd: rd_q, rd_valid: rd_valid_q, rd_data: rdata_ext};
                fault_q   <= 1'b0;
            end else if (mem_ready) begin
                mem_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv_mem_stage.sv
// tb_rv_mem_stage: randomized and directed checks of rv_mem_stage against a lane-level reference model
module tb_rv_mem_stage;
    import rvcpu::*;
    logic clk = 1'b0, rst;
    always #5 clk = ~clk;
    logic ex_valid, ex_ready, dmem_req, dmem_gnt, dmem_we, dmem_rvalid, mem_valid, mem_ready, mem_fault;
    stage_ex_t ex_in;
    mem_req_t ex_mem;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0] dmem_be;
    stage_mem_t mem_out;
    int total = 0, bad = 0;
`ifdef RVCPU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    rv_mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_in(ex_in), .ex_mem(ex_mem),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_out(mem_out), .mem_fault(mem_fault)
    );

    function automatic int nbytes(mem_size_t s);
        return s == sz_byte ? 1 : s == sz_half ? 2 : 4;
    endfunction
    // first lane touched: the address rounded down to the access size
    function automatic int lane0(mem_size_t s, logic [31:0] a);
        int off = int'(a % 4);
        return off - (off % nbytes(s));
    endfunction
    function automatic logic [3:0] ref_be(mem_size_t s, logic [31:0] a);
        logic [3:0] r = '0;
        for (int i = 0; i < nbytes(s); i++) r[lane0(s, a) + i] = 1'b1;
        return r;
    endfunction
    function automatic logic [31:0] ref_wdata(mem_size_t s, logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(s)) +: 8];
        return r;
    endfunction
    function automatic logic [31:0] ref_load(mem_size_t s, logic uns, logic [31:0] a, logic [31:0] w);
        int n = nbytes(s);
        logic [31:0] v = w >> (8 * lane0(s, a));
        logic [31:0] mask;
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v = v & mask;
            if (!uns && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction
    function automatic bit ref_misal(mem_size_t s, logic [31:0] a);
        return (nbytes(s) == 2 && a % 2 != 0) || (nbytes(s) == 4 && a % 4 != 0);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input mem_op_t op, input mem_size_t sz, input logic uns, input logic [31:0] res,
                         input logic [31:0] wd, input logic [31:0] pc, input logic [4:0] rd, input logic rdv);
        ex_valid = 1'b1;
        ex_in = '{pc: pc, rd: rd, rd_valid: rdv, res: res};
        ex_mem = '{op: op, size: sz, is_unsigned: uns, wdata: wd};
        #1;
    endtask
    task automatic quiet;
        ex_valid = 1'b0;
        ex_in = '0;
        ex_mem = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1; quiet(); dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; mem_ready = 1;
        step(); step();
        total++;
        if ({mem_valid, dmem_req, mem_fault, dmem_we, dmem_be} !== 8'h0 || mem_out !== '0 || dmem_addr !== 0 || dmem_wdata !== 0) begin
            bad++; $display("FAIL reset_vals got v=%b req=%b f=%b we=%b be=%h out=%h addr=%h wd=%h want all zero",
                mem_valid, dmem_req, mem_fault, dmem_we, dmem_be, mem_out, dmem_addr, dmem_wdata);
        end
        rst = 1'b0; #1;
        total++;
        if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ex_ready); end
    endtask

    task automatic test_passthrough;
        stage_mem_t exp;
        for (int i = 0; i < 4; i++) begin
            drive(mem_none, sz_word, 1'b0, 32'h1234, 32'h0, 32'h1000 + 32'(4 * i), 5'd5, 1'b1);
            total++;
            if (ex_ready !== 1'b1) begin bad++; $display("FAIL pt_ready%0d got=%b want=1", i, ex_ready); end
            step();
            exp = '{pc: 32'h1000 + 32'(4 * i), rd: 5'd5, rd_valid: 1'b1, rd_data: 32'h1234};
            total++;
            if (mem_valid !== 1'b1 || mem_out !== exp || dmem_req !== 1'b0) begin
                bad++; $display("FAIL pt_beat%0d got v=%b out=%h req=%b want v=1 out=%h req=0", i, mem_valid, mem_out, dmem_req, exp);
            end
        end
        quiet(); step();
        total++;
        if (mem_valid !== 1'b0) begin bad++; $display("FAIL pt_drain got=%b want=0", mem_valid); end
    endtask

    task automatic test_load_byte;
        stage_mem_t exp;
        for (int u = 0; u < 2; u++) begin
            drive(mem_load, sz_byte, u[0], 32'h103, 32'h0, 32'h2000, 5'd7, 1'b1);
            step(); quiet();
            total++;
            if ({dmem_req, dmem_we, dmem_be, ex_ready} !== 7'b1010000 || dmem_addr !== 32'h100) begin
                bad++; $display("FAIL lb_req%0d got req=%b we=%b be=%b rdy=%b addr=%h want req=1 we=0 be=1000 rdy=0 addr=100",
                    u, dmem_req, dmem_we, dmem_be, ex_ready, dmem_addr);
            end
            dmem_gnt = 1; step(); dmem_gnt = 0;
            total++;
            if (dmem_req !== 1'b0 || mem_valid !== 1'b0) begin
                bad++; $display("FAIL lb_rsp%0d got req=%b v=%b want 0 0", u, dmem_req, mem_valid);
            end
            dmem_rvalid = 1; dmem_rdata = 32'h8011_2233; step(); dmem_rvalid = 0;
            exp = '{pc: 32'h2000, rd: 5'd7, rd_valid: 1'b1, rd_data: u ? 32'h0000_0080 : 32'hFFFF_FF80};
            total++;
            if (mem_valid !== 1'b1 || mem_out !== exp) begin
                bad++; $display("FAIL lb_data%0d got v=%b out=%h want v=1 out=%h", u, mem_valid, mem_out, exp);
            end
            step();
        end
    endtask

    task automatic test_store_half;
        drive(mem_store, sz_half, 1'b0, 32'h202, 32'h1234_ABCD, 32'h3000, 5'd9, 1'b1);
        step(); quiet();
        for (int c = 0; c < 4; c++) begin
            dmem_gnt = (c == 3);
            #1;
            total++;
            if ({dmem_req, dmem_we, dmem_be, ex_ready, mem_valid} !== 8'b11110000 || dmem_addr !== 32'h200 || dmem_wdata !== 32'hABCD_ABCD) begin
                bad++; $display("FAIL sh_hold%0d got req=%b we=%b be=%b rdy=%b v=%b addr=%h wd=%h want 1 1 1100 0 0 200 abcdabcd",
                    c, dmem_req, dmem_we, dmem_be, ex_ready, mem_valid, dmem_addr, dmem_wdata);
            end
            step();
        end
        dmem_gnt = 0;
        total++;
        if (mem_valid !== 1'b1 || mem_out.rd_valid !== 1'b0 || mem_out.pc !== 32'h3000 || mem_out.rd !== 5'd9 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL sh_done got v=%b rdv=%b pc=%h rd=%0d req=%b want 1 0 3000 9 0",
                mem_valid, mem_out.rd_valid, mem_out.pc, mem_out.rd, dmem_req);
        end
        step();
    endtask

    task automatic test_backpressure;
        stage_mem_t exp, exp2;
        logic [31:0] w = $urandom;
        drive(mem_load, sz_word, 1'b0, 32'h400, 32'h0, 32'h4000, 5'd11, 1'b1);
        step(); quiet();
        dmem_gnt = 1; step(); dmem_gnt = 0;
        mem_ready = 0; dmem_rvalid = 1; dmem_rdata = w; step(); dmem_rvalid = 0;
        exp = '{pc: 32'h4000, rd: 5'd11, rd_valid: 1'b1, rd_data: w};
        drive(mem_none, sz_word, 1'b0, 32'h55AA, 32'h0, 32'h4100, 5'd12, 1'b1);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (mem_valid !== 1'b1 || mem_out !== exp || ex_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got v=%b out=%h rdy=%b want v=1 out=%h rdy=0", c, mem_valid, mem_out, ex_ready, exp);
            end
            step();
        end
        mem_ready = 1; #1;
        total++;
        if (ex_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", ex_ready); end
        step(); quiet();
        exp2 = '{pc: 32'h4100, rd: 5'd12, rd_valid: 1'b1, rd_data: 32'h55AA};
        total++;
        if (mem_valid !== 1'b1 || mem_out !== exp2) begin
            bad++; $display("FAIL bp_next got v=%b out=%h want v=1 out=%h", mem_valid, mem_out, exp2);
        end
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF; step(); dmem_rvalid = 0; step();
        total++;
        if (mem_valid !== 1'b0 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL bp_spurious got v=%b req=%b want 0 0", mem_valid, dmem_req);
        end
    endtask

    task automatic test_misalign;
        drive(mem_load, sz_word, 1'b0, 32'h101, 32'h0, 32'h5000, 5'd3, 1'b1);
        step(); quiet();
`ifdef RVCPU_MISALIGN_TRAP_EN
        total++;
        if (dmem_req !== 1'b0 || mem_valid !== 1'b1 || mem_fault !== 1'b1 || mem_out.rd_valid !== 1'b0 || mem_out.pc !== 32'h5000) begin
            bad++; $display("FAIL mis_trap got req=%b v=%b f=%b rdv=%b pc=%h want 0 1 1 0 5000",
                dmem_req, mem_valid, mem_fault, mem_out.rd_valid, mem_out.pc);
        end
        step();
        total++;
        if (mem_valid !== 1'b0 || dmem_req !== 1'b0) begin
            bad++; $display("FAIL mis_after got v=%b req=%b want 0 0", mem_valid, dmem_req);
        end
`else
        total++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111) begin
            bad++; $display("FAIL mis_align got req=%b addr=%h be=%b want 1 100 1111", dmem_req, dmem_addr, dmem_be);
        end
        dmem_gnt = 1; step(); dmem_gnt = 0;
        dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D; step(); dmem_rvalid = 0;
        total++;
        if (mem_valid !== 1'b1 || mem_fault !== 1'b0 || mem_out.rd_data !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL mis_data got v=%b f=%b d=%h want 1 0 cafef00d", mem_valid, mem_fault, mem_out.rd_data);
        end
        step();
`endif
    endtask

    task automatic test_reset_mid;
        stage_mem_t exp;
        drive(mem_load, sz_byte, 1'b0, 32'h10, 32'h0, 32'h6000, 5'd4, 1'b1);
        step(); quiet();
        dmem_gnt = 1; step(); dmem_gnt = 0;
        rst = 1; step(); rst = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h0000_00FF; step(); dmem_rvalid = 0;
        total++;
        if ({mem_valid, dmem_req, mem_fault, dmem_we, dmem_be} !== 8'h0 || mem_out !== '0 || dmem_addr !== 0 || dmem_wdata !== 0 || ex_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid got v=%b req=%b f=%b we=%b be=%h out=%h addr=%h wd=%h rdy=%b want zeros rdy=1",
                mem_valid, dmem_req, mem_fault, dmem_we, dmem_be, mem_out, dmem_addr, dmem_wdata, ex_ready);
        end
        drive(mem_none, sz_word, 1'b0, 32'h77, 32'h0, 32'h6100, 5'd6, 1'b1);
        step(); quiet();
        exp = '{pc: 32'h6100, rd: 5'd6, rd_valid: 1'b1, rd_data: 32'h77};
        total++;
        if (mem_valid !== 1'b1 || mem_out !== exp) begin
            bad++; $display("FAIL rstmid_pt got v=%b out=%h want v=1 out=%h", mem_valid, mem_out, exp);
        end
        step();
    endtask

    task automatic test_random;
        for (int it = 0; it < 80; it++) begin
            mem_op_t op = mem_op_t'($urandom_range(0, 2));
            mem_size_t sz = mem_size_t'($urandom_range(0, 2));
            logic uns = 1'($urandom_range(0, 1));
            logic rdv = 1'($urandom_range(0, 1));
            logic [31:0] a = $urandom, wd = $urandom, pc = $urandom & ~32'h3, rdata = $urandom;
            logic [4:0] rd = 5'($urandom_range(0, 31));
            int gd = $urandom_range(0, 3), rl = $urandom_range(1, 3);
            bit trap = TrapEn && op != mem_none && ref_misal(sz, a);
            drive(op, sz, uns, a, wd, pc, rd, rdv);
            total++;
            if (ex_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready%0d got=%b want=1", it, ex_ready); end
            step(); quiet();
            if (op == mem_none || trap) begin
                total++;
                if (mem_valid !== 1'b1 || mem_fault !== trap || dmem_req !== 1'b0 || mem_out.pc !== pc || mem_out.rd !== rd ||
                    mem_out.rd_valid !== (rdv && !trap) || (!trap && mem_out.rd_data !== a)) begin
                    bad++; $display("FAIL rnd_pt%0d got v=%b f=%b req=%b out=%h want f=%b pc=%h rd=%0d rdv=%b d=%h",
                        it, mem_valid, mem_fault, dmem_req, mem_out, trap, pc, rd, rdv && !trap, a);
                end
            end else begin
                for (int c = 0; c <= gd; c++) begin
                    dmem_gnt = (c == gd);
                    dmem_rvalid = 1'($urandom_range(0, 1));
                    #1;
                    total++;
                    if (dmem_req !== 1'b1 || dmem_we !== (op == mem_store) || dmem_addr !== (a & ~32'h3) ||
                        dmem_be !== ref_be(sz, a) || dmem_wdata !== ref_wdata(sz, wd) || mem_valid !== 1'b0) begin
                        bad++; $display("FAIL rnd_req%0d got req=%b we=%b addr=%h be=%b wd=%h v=%b want addr=%h be=%b wd=%h",
                            it, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_valid, a & ~32'h3, ref_be(sz, a), ref_wdata(sz, wd));
                    end
                    step();
                end
                dmem_gnt = 0; dmem_rvalid = 0;
                if (op == mem_store) begin
                    total++;
                    if (mem_valid !== 1'b1 || mem_out.rd_valid !== 1'b0 || mem_out.pc !== pc || mem_out.rd !== rd || mem_fault !== 1'b0) begin
                        bad++; $display("FAIL rnd_st%0d got v=%b out=%h f=%b want v=1 pc=%h rd=%0d rdv=0", it, mem_valid, mem_out, mem_fault, pc, rd);
                    end
                end else begin
                    for (int c = 1; c < rl; c++) begin
                        dmem_gnt = 1'($urandom_range(0, 1));
                        step();
                    end
                    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = rdata; step(); dmem_rvalid = 0;
                    total++;
                    if (mem_valid !== 1'b1 || mem_out.rd_data !== ref_load(sz, uns, a, rdata) || mem_out.pc !== pc ||
                        mem_out.rd !== rd || mem_out.rd_valid !== rdv || mem_fault !== 1'b0) begin
                        bad++; $display("FAIL rnd_ld%0d got v=%b out=%h f=%b want pc=%h rd=%0d rdv=%b d=%h",
                            it, mem_valid, mem_out, mem_fault, pc, rd, rdv, ref_load(sz, uns, a, rdata));
                    end
                end
            end
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_backpressure();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
